block_grid_renderer: RTL and testbench
======================================

// Module: block_grid_renderer
// PURPOSE
//  Parametrised VGA raster engine: generates hsync/vsync, scans a BLOCKS_WIDE x BLOCKS_HIGH grid of
//  BLOCK_SIZE-pixel cells centred in the active area, fetches one byte per cell from external image BRAM.
//  Supports NUM_IMAGES stored images, switched glitch-free at frame boundaries via a req/ack handshake.
//  Sits between the image BRAM and the VGA pins; replaces hard-coded timing/offsets with parameters.
// PARAMETERS
//  H_ACTIVE 640 / H_FP 16 / H_SYNC 96 / H_BP 48 : horizontal timing in pixels; H_TOTAL = sum
//  V_ACTIVE 480 / V_FP 10 / V_SYNC 2 / V_BP 33  : vertical timing in lines; V_TOTAL = sum
//  CLK_DIV     4     : clk cycles per pixel tick (>=2)
//  BLOCK_SIZE  16    : cell edge in pixels
//  BLOCKS_WIDE 28    : cells per row
//  BLOCKS_HIGH 28    : cells per column
//  NUM_IMAGES  10    : images in BRAM
//  IMG_STRIDE  1024  : BRAM words per image (>= BLOCKS_WIDE*BLOCKS_HIGH)
//  ADDR_W      16    : BRAM address width
//  RGB_W       8     : colour width (RRRGGGBB)
//  GRID_COLOR  8'hE0 : grid-line colour (GRID_LINES_EN only)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous reset, active high
//  img_req      in   1        request to switch displayed image
//  img_sel      in   4        requested image index, sampled with img_req
//  img_ack      out  1        1-clk pulse: request applied at frame start
//  img_err      out  1        1-clk pulse: request rejected (img_sel >= NUM_IMAGES)
//  cur_img      out  4        image index currently displayed
//  mem_addr     out  ADDR_W   BRAM read address
//  mem_en       out  1        BRAM read enable (high while in grid)
//  mem_data     in   RGB_W    BRAM read data, valid CLK_DIV-1 clks after mem_addr update
//  frame_start  out  1        1-clk pulse when h_cnt=0,v_cnt=0 on a pixel tick
//  rgb          out  RGB_W    pixel colour
//  hsync        out  1        active-low horizontal sync
//  vsync        out  1        active-low vertical sync
// BEHAVIOUR
//  - Reset: divider, h_cnt, v_cnt=0; rgb=0; hsync=vsync=1; mem_addr=0; mem_en=0; cur_img=0;
//    img_ack=img_err=frame_start=0; pending request cleared. rst mid-frame restarts at pixel (0,0).
//  - pix_en: 1-clk pulse every CLK_DIV clks; counters and all pipeline stages advance only on pix_en.
//  - h_cnt 0..H_TOTAL-1, wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1, wraps to 0.
//  - Sync (pre-delay): hsync low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise.
//  - Grid: X0=(H_ACTIVE-BLOCK_SIZE*BLOCKS_WIDE)/2, Y0 likewise; in_grid iff X0<=h_cnt<X0+BS*BW and
//    Y0<=v_cnt<Y0+BS*BH (inclusive/exclusive). i=(h_cnt-X0)/BLOCK_SIZE, j=(v_cnt-Y0)/BLOCK_SIZE.
//  - Stage 1 (pix_en): mem_addr <= cur_img*IMG_STRIDE + j*BLOCKS_WIDE + i (truncated to ADDR_W);
//    mem_en <= in_grid; in_grid/hsync/vsync delayed alongside.
//  - Stage 2 (pix_en): rgb <= in_grid_d ? mem_data : 0; hsync/vsync output in same stage.
//  - Latency: rgb, hsync, vsync all exactly 2 pixel ticks behind counters; always mutually aligned.
//  - Handshake: img_req high on a clk latches img_sel into pending (later req overwrites pending).
//    Out of range: img_err pulse next clk, pending unchanged. At frame_start with pending valid:
//    cur_img <= pending, img_ack pulse same clk, pending cleared. req on same clk as frame_start:
//    old pending applied, new one waits for next frame. cur_img never changes mid-frame.
// CONFIGURATION
//  GRID_LINES_EN defined: in_grid pixels with (h_cnt-X0)%BLOCK_SIZE==0 or (v_cnt-Y0)%BLOCK_SIZE==0
//    output GRID_COLOR instead of mem_data (same latency). Not defined: no grid logic, GRID_COLOR unused.
// TESTING
//  1 Defaults, run 2 frames: hsync low 96 ticks/line at h 656..751, vsync low lines 490..491, 525 lines/frame.
//  2 BRAM model addr->addr[7:0], cur_img=0: cell (i=0,j=0) rgb=0x00 at tick X0=96+2; cell (27,27) addr 783 -> 0x0F.
//  3 img_req img_sel=3 mid-frame -> cur_img stays 0 until frame_start; then cur_img=3, img_ack 1 clk, addr base 3072.
//  4 img_req img_sel=12 -> img_err 1 clk, no ack, cur_img unchanged.
//  5 rst asserted mid-line -> next clk rgb=0, hsync=vsync=1; after release counters restart at (0,0).
//  6 GRID_LINES_EN, BLOCK_SIZE=8: grid pixel at X0 -> rgb=0xE0; pixel X0+1 -> mem_data.

Source files
------------

// File: rtl/block_grid_renderer.sv
// Parametrised VGA raster engine: sync generation, centred block grid fetched from image BRAM,
// glitch-free image switching at frame start. Optional grid overlay enabled by macro GRID_LINES_EN.
module block_grid_renderer #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int CLK_DIV     = 4,
  parameter int BLOCK_SIZE  = 16,
  parameter int BLOCKS_WIDE = 28,
  parameter int BLOCKS_HIGH = 28,
  parameter int NUM_IMAGES  = 10,
  parameter int IMG_STRIDE  = 1024,
  parameter int ADDR_W      = 16,
  parameter int RGB_W       = 8,
  parameter logic [RGB_W-1:0] GRID_COLOR = RGB_W'(8'hE0)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_req,
  input  logic [3:0]        img_sel,
  output logic              img_ack,
  output logic              img_err,
  output logic [3:0]        cur_img,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [RGB_W-1:0]  mem_data,
  output logic              frame_start,
  output logic [RGB_W-1:0]  rgb,
  output logic              hsync,
  output logic              vsync
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int GRID_W   = BLOCK_SIZE * BLOCKS_WIDE;
  localparam int GRID_H   = BLOCK_SIZE * BLOCKS_HIGH;
  localparam int X0       = (H_ACTIVE - GRID_W) / 2;
  localparam int Y0       = (V_ACTIVE - GRID_H) / 2;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int D_W      = $clog2(CLK_DIV);

  logic [D_W-1:0]    r_div;
  logic [H_W-1:0]    r_h_cnt;
  logic [V_W-1:0]    r_v_cnt;
  logic              r_in_grid_d, r_hs_d, r_vs_d;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_en;
  logic [RGB_W-1:0]  r_rgb;
  logic              r_hsync, r_vsync;
  logic [3:0]        r_cur_img, r_pend_img;
  logic              r_pend_valid;
  logic              r_img_ack, r_img_err, r_frame_start;

  int   w_h, w_v, w_i, w_j, w_addr;
  logic w_pix_en, w_fs, w_in_grid, w_hs_n, w_vs_n, w_sel_ok;

  assign w_h       = int'(r_h_cnt);
  assign w_v       = int'(r_v_cnt);
  assign w_pix_en  = (r_div == D_W'(CLK_DIV - 1));
  assign w_fs      = w_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_in_grid = (w_h >= X0) && (w_h < X0 + GRID_W) && (w_v >= Y0) && (w_v < Y0 + GRID_H);
  assign w_i       = (w_h - X0) / BLOCK_SIZE;
  assign w_j       = (w_v - Y0) / BLOCK_SIZE;
  assign w_addr    = int'(r_cur_img) * IMG_STRIDE + w_j * BLOCKS_WIDE + w_i;
  assign w_hs_n    = !((w_h >= HS_START) && (w_h < HS_START + H_SYNC));
  assign w_vs_n    = !((w_v >= VS_START) && (w_v < VS_START + V_SYNC));
  assign w_sel_ok  = int'(img_sel) < NUM_IMAGES;

`ifdef GRID_LINES_EN
  logic w_grid_line, r_grid_d;
  assign w_grid_line = w_in_grid &&
                       ((((w_h - X0) % BLOCK_SIZE) == 0) || (((w_v - Y0) % BLOCK_SIZE) == 0));
`else
  logic w_unused_grid;
  assign w_unused_grid = ^GRID_COLOR;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + D_W'(1);
      if (w_pix_en) begin
        if (r_h_cnt == H_W'(H_TOTAL - 1)) begin
          r_h_cnt <= '0;
          r_v_cnt <= (r_v_cnt == V_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + V_W'(1);
        end else begin
          r_h_cnt <= r_h_cnt + H_W'(1);
        end
      end
    end
  end

  // Two-stage pixel pipeline: address/flags, then colour; syncs ride along to stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_en    <= 1'b0;
      r_in_grid_d <= 1'b0;
      r_hs_d      <= 1'b1;
      r_vs_d      <= 1'b1;
      r_rgb       <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
`ifdef GRID_LINES_EN
      r_grid_d    <= 1'b0;
`endif
    end else if (w_pix_en) begin
      r_mem_addr  <= ADDR_W'(w_addr);
      r_mem_en    <= w_in_grid;
      r_in_grid_d <= w_in_grid;
      r_hs_d      <= w_hs_n;
      r_vs_d      <= w_vs_n;
      r_hsync     <= r_hs_d;
      r_vsync     <= r_vs_d;
`ifdef GRID_LINES_EN
      r_grid_d    <= w_grid_line;
      r_rgb       <= r_in_grid_d ? (r_grid_d ? GRID_COLOR : mem_data) : '0;
`else
      r_rgb       <= r_in_grid_d ? mem_data : '0;
`endif
    end
  end

  // A request arriving on the frame_start clock is kept for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_img     <= '0;
      r_pend_img    <= '0;
      r_pend_valid  <= 1'b0;
      r_img_ack     <= 1'b0;
      r_img_err     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_fs;
      r_img_ack     <= w_fs && r_pend_valid;
      r_img_err     <= img_req && !w_sel_ok;
      if (w_fs && r_pend_valid) r_cur_img <= r_pend_img;
      if (img_req && w_sel_ok) begin
        r_pend_img   <= img_sel;
        r_pend_valid <= 1'b1;
      end else if (w_fs) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_en      = r_mem_en;
  assign rgb         = r_rgb;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign cur_img     = r_cur_img;
  assign img_ack     = r_img_ack;
  assign img_err     = r_img_err;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_block_grid_renderer.sv
// Directed bench for block_grid_renderer on a reduced raster (56x32 ticks, 8x4 grid of 4-px cells at 4,4).
module tb_block_grid_renderer;

  localparam int CLK_DIV = 4;
  localparam int H_TOTAL = 56;
  localparam int FRAME   = 56 * 32;

  logic        clk = 1'b0;
  logic        rst, img_req;
  logic [3:0]  img_sel;
  logic        img_ack, img_err, mem_en, frame_start, hsync, vsync;
  logic [3:0]  cur_img;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, rgb;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int fs_cnt = 0, ack_cnt = 0, err_cnt = 0;

  logic [7:0]  a_rgb  [FRAME];
  logic [15:0] a_addr [FRAME];
  logic        a_hs   [FRAME];
  logic        a_vs   [FRAME];
  logic        a_en   [FRAME];

  block_grid_renderer #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .CLK_DIV(CLK_DIV), .BLOCK_SIZE(4), .BLOCKS_WIDE(8), .BLOCKS_HIGH(4),
    .NUM_IMAGES(10), .IMG_STRIDE(64), .ADDR_W(16), .RGB_W(8)
  ) dut (
    .clk(clk), .rst(rst), .img_req(img_req), .img_sel(img_sel),
    .img_ack(img_ack), .img_err(img_err), .cur_img(cur_img),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .frame_start(frame_start), .rgb(rgb), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  // Image BRAM stand-in: one-clock read latency, data = low address byte.
  always @(posedge clk) mem_data <= mem_addr[7:0];

  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (img_ack)     ack_cnt++;
    if (img_err)     err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int h, input int v);
    return v * H_TOTAL + h;
  endfunction

  // After the n-th pixel tick past frame_start, the outputs show pixel n-1.
  task automatic step();
    repeat (CLK_DIV) @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_req(input logic [3:0] sel, output logic err_now);
    img_req = 1'b1;
    img_sel = sel;
    @(posedge clk);
    #1;
    img_req = 1'b0;
    err_now = img_err;
    repeat (CLK_DIV - 1) @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_fs(input int max_clk, output int clks);
    clks = 0;
    do begin
      @(posedge clk);
      #1;
      clks++;
    end while (!frame_start && clks < max_clk);
    check("fs_seen", frame_start, 1);
    n = 0;
  endtask

  task automatic scan_frame();
    for (int p = 0; p < FRAME; p++) begin
      step();
      a_rgb[p]  = rgb;
      a_addr[p] = mem_addr;
      a_hs[p]   = hsync;
      a_vs[p]   = vsync;
      a_en[p]   = mem_en;
    end
    check("fs_period", frame_start, 1);
    n = 0;
  endtask

  initial begin
    int   clks;
    int   cnt;
    logic e5, e3, e12;

    rst = 1'b1; img_req = 1'b0; img_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 8'h00);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_en", mem_en, 0);
    check("rst_cur", cur_img, 0);
    check("rst_pulses", {img_ack, img_err, frame_start}, 3'b000);
    rst = 1'b0;
    wait_fs(4 * CLK_DIV, clks);

    // Frame 1: timing and grid contents with image 0
    scan_frame();
    cnt = 0;
    for (int h = 0; h < H_TOTAL; h++) if (!a_hs[h]) cnt++;
    check("hs_low_ticks", cnt, 6);
    check("hs_43", a_hs[idx(43, 0)], 1);
    check("hs_44", a_hs[idx(44, 0)], 0);
    check("hs_49", a_hs[idx(49, 0)], 0);
    check("hs_50", a_hs[idx(50, 0)], 1);
    cnt = 0;
    for (int p = 0; p < FRAME; p++) if (!a_vs[p]) cnt++;
    check("vs_low_ticks", cnt, 112);
    check("vs_l25", a_vs[idx(55, 25)], 1);
    check("vs_l26", a_vs[idx(0, 26)], 0);
    check("vs_l27", a_vs[idx(55, 27)], 0);
    check("vs_l28", a_vs[idx(0, 28)], 1);
    check("rgb_c10", a_rgb[idx(8, 4)], 8'h01);
    check("rgb_c01", a_rgb[idx(4, 8)], 8'h08);
    check("rgb_c73", a_rgb[idx(35, 19)], 8'h1F);
    check("rgb_right", a_rgb[idx(36, 19)], 8'h00);
    check("rgb_left", a_rgb[idx(3, 4)], 8'h00);
    check("rgb_above", a_rgb[idx(8, 3)], 8'h00);
    check("rgb_below", a_rgb[idx(8, 20)], 8'h00);
    check("en_enter", a_en[idx(3, 4)], 1);
    check("en_last", a_en[idx(34, 19)], 1);
    check("en_exit", a_en[idx(35, 19)], 0);
    check("addr_c10", a_addr[idx(7, 4)], 16'd1);

    // Frame 2: requests mid-frame; pending overwritten, bad index rejected
    for (int k = 0; k < 100; k++) step();
    step_req(4'd5, e5);
    step_req(4'd3, e3);
    step_req(4'd12, e12);
    check("err_ok_sel", e3, 0);
    check("err_bad_sel", e12, 1);
    check("cur_midframe", cur_img, 0);
    check("no_early_ack", ack_cnt, 0);
    while (n < FRAME) step();
    check("fs_frame2", frame_start, 1);
    check("ack_at_fs", img_ack, 1);
    check("cur_switched", cur_img, 3);
    n = 0;

    // Frame 3: image 3 lives at base 192
    scan_frame();
    check("img3_c10", a_rgb[idx(8, 4)], 8'hC1);
    check("img3_c73", a_rgb[idx(35, 19)], 8'hDF);
    check("img3_addr", a_addr[idx(7, 4)], 16'd193);
    check("img3_out", a_rgb[idx(36, 19)], 8'h00);
    check("cur_held", cur_img, 3);

    // Frame 4: reset in the middle of hsync
    for (int k = 0; k < 47; k++) step();
    check("pre_rst_hs", hsync, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_rgb", rgb, 8'h00);
    check("mid_rst_hs", hsync, 1);
    check("mid_rst_vs", vsync, 1);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_cur", cur_img, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_fs(4 * CLK_DIV, clks);
    check("restart_clks", clks <= CLK_DIV, 1);
    for (int k = 0; k < idx(8, 4) + 1; k++) step();
    check("restart_c10", rgb, 8'h01);

    check("fs_pulses", fs_cnt, 5);
    check("ack_pulses", ack_cnt, 1);
    check("err_pulses", err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
